// File: rtl/sbox_pipe.sv
// sbox_pipe: three-stage, multi-lane AES S-box (SubBytes, optionally InvSubBytes) with valid/ready flow.
// Define SBOX_INV_EN to build in the inverse mode; otherwise every word is processed forward.
module sbox_pipe #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [8*LANES-1:0] out_data
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
    return r ^ 8'h63;
  endfunction

`ifdef SBOX_INV_EN
  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    return r ^ 8'h05;
  endfunction
`endif

  // First half of x^254: returns {x^14, x^240}; x^240 * x^14 finishes the inverse.
  function automatic logic [15:0] inv_half(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x14, x15, x240;
    x2   = gf_sq(x);
    x3   = gf_mul(x2, x);
    x12  = gf_sq(gf_sq(x3));
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x240 = gf_sq(gf_sq(gf_sq(gf_sq(x15))));
    return {x14, x240};
  endfunction

  logic               v1, v2, v3;
  logic               ld1, ld2, ld3;
  logic [8*LANES-1:0] d1;
  logic [8*LANES-1:0] x14_r, x240_r;
  logic [8*LANES-1:0] s1_next, s2_x14, s2_x240, s3_next;

`ifdef SBOX_INV_EN
  logic m1, m2, m3;
`else
  logic unused_mode;
  assign unused_mode = in_mode;
`endif

  // Each stage may load when empty or when its current word moves on this cycle.
  assign ld3       = ~v3 | out_ready;
  assign ld2       = ~v2 | ld3;
  assign ld1       = ~v1 | ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  always_comb begin
    s1_next = in_data;
    s2_x14  = '0;
    s2_x240 = '0;
    s3_next = '0;
    for (int k = 0; k < LANES; k++) begin
`ifdef SBOX_INV_EN
      s1_next[8*k +: 8] = in_mode ? affine_inv(in_data[8*k +: 8]) : in_data[8*k +: 8];
`endif
      {s2_x14[8*k +: 8], s2_x240[8*k +: 8]} = inv_half(d1[8*k +: 8]);
`ifdef SBOX_INV_EN
      s3_next[8*k +: 8] = m2 ? gf_mul(x240_r[8*k +: 8], x14_r[8*k +: 8])
                             : affine_fwd(gf_mul(x240_r[8*k +: 8], x14_r[8*k +: 8]));
`else
      s3_next[8*k +: 8] = affine_fwd(gf_mul(x240_r[8*k +: 8], x14_r[8*k +: 8]));
`endif
    end
  end

  // Data registers only capture when a valid word enters, so stalled or empty stages hold their contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      d1       <= '0;
      x14_r    <= '0;
      x240_r   <= '0;
      out_data <= '0;
`ifdef SBOX_INV_EN
      m1       <= 1'b0;
      m2       <= 1'b0;
      m3       <= 1'b0;
`endif
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid) begin
          d1 <= s1_next;
`ifdef SBOX_INV_EN
          m1 <= in_mode;
`endif
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          x14_r  <= s2_x14;
          x240_r <= s2_x240;
`ifdef SBOX_INV_EN
          m2     <= m1;
`endif
        end
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) begin
          out_data <= s3_next;
`ifdef SBOX_INV_EN
          m3       <= m2;
`endif
        end
      end
    end
  end

`ifdef SBOX_INV_EN
  assign out_mode = m3;
`else
  assign out_mode = 1'b0;
`endif

endmodule

// File: tb/tb_sbox_pipe.sv
// tb_sbox_pipe: scoreboard bench for sbox_pipe; expected words are queued at acceptance, checked by a monitor.
// Expectations follow SBOX_INV_EN: without it every word is expected forward with out_mode 0.
`timescale 1ns/1ps
module tb_sbox_pipe;
  localparam int LANES = 4;
  localparam int W     = 8*LANES;
`ifdef SBOX_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_mode;
  logic [W-1:0] out_data;

  typedef struct packed {
    logic [W-1:0] data;
    logic         mode;
  } exp_t;

  exp_t sb_q[$];
  int   pop_cycles[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] sbox_tbl [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  logic [7:0] inv_tbl [0:255];

  sbox_pipe #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [W-1:0] model_data(input logic [W-1:0] d, input logic m);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      r[8*k +: 8] = (m && INV_EN) ? inv_tbl[d[8*k +: 8]] : sbox_tbl[d[8*k +: 8]];
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unexpected_output: got out_data %h with nothing outstanding, required no output", out_data);
    end else begin
      e = sb_q.pop_front();
      pop_cycles.push_back(cyc);
      checkVal("out_data", out_data, e.data);
      checkVal("out_mode", W'(out_mode), W'(e.mode));
    end
  endtask

  // Monitor: a word transfers at the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) checkOutput();
  end

  task automatic applyStimulus(input logic [W-1:0] d, input logic m, input logic [W-1:0] ed,
                               input logic em, input int max_wait, output bit ok);
    exp_t e;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = ed;
        e.mode = em;
        sb_q.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checkVal("drain_outstanding", W'(sb_q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit           ok;
    int           acc;
    int           misses;
    int           n;
    int           seen;
    logic [7:0]   b;
    logic [W-1:0] w;
    logic [W-1:0] bp_words [5];

    for (int i = 0; i < 256; i++) inv_tbl[sbox_tbl[i]] = 8'(i);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("reset_out_valid", W'(out_valid), '0);
    checkVal("reset_out_data", out_data, '0);
    checkVal("reset_out_mode", W'(out_mode), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkVal("reset_in_ready", W'(in_ready), W'(1'b1));
    @(posedge clk);
    #1;

    $display("[TB] directed forward vector with latency");
    applyStimulus(32'hFF53_0100, 1'b0, 32'h16ED_7C63, 1'b0, 4, ok);
    in_valid = 1'b0;
    checkVal("fwd_accepted", W'(ok), W'(1'b1));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkVal($sformatf("fwd_latency_c%0d", c), W'(out_valid), W'(c == 3));
      @(posedge clk);
    end
    #1;
    waitDrain(10);

`ifdef SBOX_INV_EN
    $display("[TB] directed inverse vector");
    applyStimulus(32'h16ED_7C63, 1'b1, 32'hFF53_0100, 1'b1, 4, ok);
`else
    $display("[TB] inverse request is processed forward in this build");
    applyStimulus(32'h16ED_7C63, 1'b1, 32'h4755_10FB, 1'b0, 4, ok);
`endif
    in_valid = 1'b0;
    checkVal("mode1_accepted", W'(ok), W'(1'b1));
    waitDrain(10);

    $display("[TB] all 256 bytes, back to back, alternating mode");
    pop_cycles.delete();
    misses = 0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      w = {LANES{b}};
      applyStimulus(w, b[0], model_data(w, b[0]), b[0] & INV_EN, 1, ok);
      if (!ok) misses++;
    end
    in_valid = 1'b0;
    waitDrain(20);
    checkVal("sweep_input_stalls", W'(misses), '0);
    checkVal("sweep_output_count", W'(pop_cycles.size()), W'(256));
    if (pop_cycles.size() == 256)
      checkVal("sweep_output_span", W'(pop_cycles[255] - pop_cycles[0]), W'(255));

    $display("[TB] backpressure with five offered words");
    bp_words = '{32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF, 32'h0F1E_2D3C};
    pop_cycles.delete();
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(bp_words[i], 1'(i), model_data(bp_words[i], 1'(i)), 1'(i) & INV_EN, 3, ok);
      if (ok) acc++;
    end
    in_valid = 1'b0;
    checkVal("bp_accepted", W'(acc), W'(3));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkVal("bp_in_ready", W'(in_ready), '0);
      checkVal("bp_out_valid", W'(out_valid), W'(1'b1));
      checkVal("bp_out_held", out_data, model_data(bp_words[0], 1'b0));
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    waitDrain(10);
    checkVal("bp_drain_count", W'(pop_cycles.size()), W'(3));

    $display("[TB] random valid/ready over 10000 words");
    n = 0;
    for (int g = 0; g < 60000 && n < 10000; g++) begin
      exp_t e;
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_mode  = 1'($urandom_range(0, 1));
        for (int k = 0; k < LANES; k++) in_data[8*k +: 8] = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      ok = 1'b0;
      if (in_valid && in_ready) begin
        e.data = model_data(in_data, in_mode);
        e.mode = in_mode & INV_EN;
        sb_q.push_back(e);
        ok = 1'b1;
        n++;
      end
      @(posedge clk);
      #1;
      if (ok) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkVal("random_word_count", W'(n), W'(10000));
    waitDrain(20);

    $display("[TB] reset with two words in flight");
    applyStimulus(32'h0102_0304, 1'b0, model_data(32'h0102_0304, 1'b0), 1'b0, 2, ok);
    applyStimulus(32'hA0B0_C0D0, 1'b1, model_data(32'hA0B0_C0D0, 1'b1), INV_EN, 2, ok);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkVal("rst_out_valid", W'(out_valid), '0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkVal("rst_in_ready", W'(in_ready), W'(1'b1));
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkVal("rst_no_stale_output", W'(seen), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
